// File: rtl/flash_loader.sv
// flash_loader: parses addr/count/data byte packets and writes 16-bit words to a flash port.
// Optional readback verify is compiled in with FLASH_LOADER_VERIFY_EN.
module flash_loader #(
    parameter int flash_width = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   mem_ce,
    output logic                   mem_we,
    output logic [flash_width-1:0] mem_a,
    output logic [15:0]            mem_wd,
    input  logic [15:0]            mem_rd,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);
    typedef enum logic [3:0] {
        IDLE, ADDR_HI, CNT_LO, CNT_HI, DAT_LO, DAT_HI, WRITE, VRD, VCMP, FIN, ERR
    } state_t;

    state_t                 r_state, w_next;
    logic [flash_width-1:0] r_addr, r_mem_a;
    logic [15:0]            r_cnt, r_mem_wd, w_pair;
    logic [7:0]             r_lo;
    logic                   r_error, w_hs, w_match, w_step, w_last;

`ifdef FLASH_LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
    assign w_match = mem_rd == r_mem_wd;
`else
    localparam bit VERIFY = 1'b0;
    logic w_unused;
    assign w_match  = 1'b1;
    assign w_unused = ^mem_rd;
`endif

    // r_lo holds whichever low byte is pending: address, count or data
    assign w_pair   = {in_data, r_lo};
    assign w_hs     = in_valid && in_ready;
    assign w_last   = r_cnt == 16'd1;
    assign w_step   = VERIFY ? (r_state == VCMP && w_match) : (r_state == WRITE);
    assign in_ready = !rst && (r_state inside {IDLE, ADDR_HI, CNT_LO, CNT_HI, DAT_LO, DAT_HI});
    assign mem_ce   = !rst && (r_state == WRITE || r_state == VRD);
    assign mem_we   = !rst && r_state == WRITE;
    assign busy     = !rst && r_state != IDLE;
    assign done     = !rst && r_state == FIN;
    assign mem_a    = r_mem_a;
    assign mem_wd   = r_mem_wd;
    assign error    = r_error;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_hs ? ADDR_HI : IDLE;
            ADDR_HI: w_next = w_hs ? CNT_LO : ADDR_HI;
            CNT_LO:  w_next = w_hs ? CNT_HI : CNT_LO;
            CNT_HI:  w_next = w_hs ? (w_pair == 16'd0 ? FIN : DAT_LO) : CNT_HI;
            DAT_LO:  w_next = w_hs ? DAT_HI : DAT_LO;
            DAT_HI:  w_next = w_hs ? WRITE : DAT_HI;
            WRITE:   w_next = VERIFY ? VRD : (w_last ? FIN : DAT_LO);
            VRD:     w_next = VCMP;
            VCMP:    w_next = w_match ? (w_last ? FIN : DAT_LO) : ERR;
            FIN:     w_next = IDLE;
            ERR:     w_next = ERR;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_mem_a  <= '0;
            r_cnt    <= '0;
            r_mem_wd <= '0;
            r_lo     <= '0;
            r_error  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_hs && (r_state == IDLE || r_state == CNT_LO || r_state == DAT_LO))
                r_lo <= in_data;
            if (w_hs && r_state == ADDR_HI)
                r_addr <= w_pair[flash_width-1:0];
            if (w_hs && r_state == CNT_HI)
                r_cnt <= w_pair;
            if (w_hs && r_state == DAT_HI) begin
                r_mem_a  <= r_addr;
                r_mem_wd <= w_pair;
            end
            if (w_step) begin
                r_addr <= r_addr + flash_width'(1);
                r_cnt  <= r_cnt - 16'd1;
            end
            if (r_state == VCMP && !w_match)
                r_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_flash_loader.sv
// tb_flash_loader: directed scenario tests for flash_loader with a one-word readback memory model.
module tb_flash_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, mem_ce, mem_we, busy, done, error;
    logic [13:0] mem_a;
    logic [15:0] mem_wd;
    logic [15:0] mem_rd = 16'h0000;
    logic        corrupt = 1'b0;
    logic [15:0] mdl_last = 16'h0000;
    logic [13:0] wa_q[$];
    logic [15:0] wd_q[$];
    int          done_cnt = 0;
    int          total = 0;
    int          bad = 0;

`ifdef FLASH_LOADER_VERIFY_EN
    localparam int DONE_LAT = 3;
`else
    localparam int DONE_LAT = 1;
`endif

    flash_loader #(.flash_width(14)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // read data returns the last written word, inverted for 0x2222 when corrupting
    always @(posedge clk) begin
        if (mem_ce && mem_we) mdl_last <= mem_wd;
        if (mem_ce && !mem_we) mem_rd <= (corrupt && mdl_last == 16'h2222) ? ~mdl_last : mdl_last;
    end

    always @(negedge clk) begin
        if (mem_ce && mem_we) begin
            wa_q.push_back(mem_a);
            wd_q.push_back(mem_wd);
        end
        if (done) done_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL handshake_timeout byte=%h", b);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL done_timeout got=0 exp=1");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (mem_ce !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL rst_ce_we got=%b%b exp=00", mem_ce, mem_we); end
        total++; if (done !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL rst_done_err got=%b%b exp=00", done, error); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        total++; if (mem_a !== 14'h0 || mem_wd !== 16'h0) begin bad++; $display("FAIL rst_mem got=%h/%h exp=0/0", mem_a, mem_wd); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        logic [7:0] pkt[8] = '{8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
        int n0 = wa_q.size();
        int d0 = done_cnt;
        int lat;
        foreach (pkt[i]) send_byte(pkt[i]);
        in_valid = 1'b0;
        total++; if (mem_ce !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL basic_write_strobe got=%b%b exp=11", mem_ce, mem_we); end
        total++; if (mem_a !== 14'h0011 || mem_wd !== 16'h5678) begin bad++; $display("FAIL basic_write_bus got=%h/%h exp=0011/5678", mem_a, mem_wd); end
        wait_done(lat);
        total++; if (lat !== DONE_LAT) begin bad++; $display("FAIL basic_done_lat got=%0d exp=%0d", lat, DONE_LAT); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_at_done got=%b exp=1", busy); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL basic_after_done got=%b%b exp=00", busy, done); end
        total++; if (mem_a !== 14'h0011 || mem_wd !== 16'h5678) begin bad++; $display("FAIL basic_hold got=%h/%h exp=0011/5678", mem_a, mem_wd); end
        total++; if (wa_q.size() - n0 !== 2) begin bad++; $display("FAIL basic_nwrites got=%0d exp=2", wa_q.size() - n0); end
        else begin
            total++; if (wa_q[n0] !== 14'h0010 || wd_q[n0] !== 16'h1234) begin bad++; $display("FAIL basic_w0 got=%h/%h exp=0010/1234", wa_q[n0], wd_q[n0]); end
            total++; if (wa_q[n0+1] !== 14'h0011 || wd_q[n0+1] !== 16'h5678) begin bad++; $display("FAIL basic_w1 got=%h/%h exp=0011/5678", wa_q[n0+1], wd_q[n0+1]); end
        end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt - d0); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL basic_error got=%b exp=0", error); end
    endtask

    task automatic test_wrap();
        logic [7:0] pkt[8] = '{8'hFF, 8'hFF, 8'h02, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22};
        int n0 = wa_q.size();
        int lat;
        foreach (pkt[i]) send_byte(pkt[i]);
        in_valid = 1'b0;
        wait_done(lat);
        @(posedge clk); #1;
        total++; if (wa_q.size() - n0 !== 2) begin bad++; $display("FAIL wrap_nwrites got=%0d exp=2", wa_q.size() - n0); end
        else begin
            total++; if (wa_q[n0] !== 14'h3FFF || wd_q[n0] !== 16'h1111) begin bad++; $display("FAIL wrap_w0 got=%h/%h exp=3fff/1111", wa_q[n0], wd_q[n0]); end
            total++; if (wa_q[n0+1] !== 14'h0000 || wd_q[n0+1] !== 16'h2222) begin bad++; $display("FAIL wrap_w1 got=%h/%h exp=0000/2222", wa_q[n0+1], wd_q[n0+1]); end
        end
    endtask

    task automatic test_zero_count();
        logic [7:0] pkt[4] = '{8'h05, 8'h00, 8'h00, 8'h00};
        int n0 = wa_q.size();
        foreach (pkt[i]) send_byte(pkt[i]);
        total++; if (done !== 1'b1 || mem_ce !== 1'b0) begin bad++; $display("FAIL zero_done got=%b ce=%b exp=1 ce=0", done, mem_ce); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL zero_after got=%b%b exp=00", done, busy); end
        total++; if (wa_q.size() !== n0) begin bad++; $display("FAIL zero_nwrites got=%0d exp=0", wa_q.size() - n0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] p1[5] = '{8'h20, 8'h00, 8'h03, 8'h00, 8'hAB};
        logic [7:0] p2[6] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'hAA, 8'h55};
        int n0 = wa_q.size();
        int lat;
        foreach (p1[i]) send_byte(p1[i]);
        in_data = 8'hCD; rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || mem_wd !== 16'h0) begin bad++; $display("FAIL mid_rst_state got=%b/%h exp=0/0000", busy, mem_wd); end
        repeat (5) @(posedge clk);
        #1;
        total++; if (wa_q.size() !== n0) begin bad++; $display("FAIL mid_no_write got=%0d exp=0", wa_q.size() - n0); end
        foreach (p2[i]) send_byte(p2[i]);
        in_valid = 1'b0;
        wait_done(lat);
        @(posedge clk); #1;
        total++; if (wa_q.size() - n0 !== 1) begin bad++; $display("FAIL mid_nwrites got=%0d exp=1", wa_q.size() - n0); end
        else begin
            total++; if (wa_q[n0] !== 14'h0000 || wd_q[n0] !== 16'h55AA) begin bad++; $display("FAIL mid_w0 got=%h/%h exp=0000/55aa", wa_q[n0], wd_q[n0]); end
        end
    endtask

    task automatic test_random_valid();
        logic [7:0]  hdr[4] = '{8'h00, 8'h01, 8'h08, 8'h00};
        logic [15:0] w;
        int n0 = wa_q.size();
        int d0 = done_cnt;
        int lat;
        for (int i = 0; i < 20; i++) begin
            w = 16'h0102 + 16'(i / 2) * 16'h1111;
            if (i >= 4 || $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 3)) begin
                    in_valid = 1'b0; in_data = 8'($urandom);
                    @(posedge clk); #1;
                end
            end
            if (i < 4) send_byte(hdr[i]);
            else begin
                w = 16'h0102 + 16'((i - 4) / 2) * 16'h1111;
                send_byte(i % 2 == 0 ? w[7:0] : w[15:8]);
            end
        end
        in_valid = 1'b0;
        wait_done(lat);
        @(posedge clk); #1;
        total++; if (wa_q.size() - n0 !== 8) begin bad++; $display("FAIL rand_nwrites got=%0d exp=8", wa_q.size() - n0); end
        else begin
            for (int i = 0; i < 8; i++) begin
                w = 16'h0102 + 16'(i) * 16'h1111;
                total++;
                if (wa_q[n0+i] !== 14'h0100 + 14'(i) || wd_q[n0+i] !== w) begin
                    bad++;
                    $display("FAIL rand_w%0d got=%h/%h exp=%h/%h", i, wa_q[n0+i], wd_q[n0+i], 14'h0100 + 14'(i), w);
                end
            end
        end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL rand_done_cnt got=%0d exp=1", done_cnt - d0); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL rand_error got=%b exp=0", error); end
    endtask

`ifdef FLASH_LOADER_VERIFY_EN
    task automatic test_verify_fail();
        logic [7:0] pkt[8] = '{8'h40, 8'h00, 8'h03, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22};
        int n0 = wa_q.size();
        int d0 = done_cnt;
        corrupt = 1'b1;
        foreach (pkt[i]) send_byte(pkt[i]);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++; if (wa_q.size() - n0 !== 2) begin bad++; $display("FAIL ver_nwrites got=%0d exp=2", wa_q.size() - n0); end
        total++; if (error !== 1'b1) begin bad++; $display("FAIL ver_error got=%b exp=1", error); end
        total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL ver_err_state got=%b%b exp=10", busy, in_ready); end
        total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL ver_done_cnt got=%0d exp=0", done_cnt - d0); end
        corrupt = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++; if (error !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ver_clear got=%b%b exp=00", error, busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero_count();
        test_reset_mid();
        test_random_valid();
`ifdef FLASH_LOADER_VERIFY_EN
        test_verify_fail();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
